// File: rtl/edge_pkg.sv
// Shared types and default widths for the pulse/edge generation blocks.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_e;

  localparam int unsigned PG_CNT_W = 8;
  localparam int unsigned PG_REP_W = 8;

endpackage

// File: rtl/load_down_counter.sv
// Loadable unsigned down-counter with zero and one flags; saturates at zero.
module load_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign one_o  = (count_q == W'(1));

endmodule

// File: rtl/pulse_generator.sv
// Programmable pulse-train generator with registered waveform and edge strobes.
module pulse_generator
  import edge_pkg::*;
#(
  parameter int unsigned CNT_W = PG_CNT_W,
  parameter int unsigned REP_W = PG_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [CNT_W-1:0] high_cycles_i,
  input  logic [CNT_W-1:0] low_cycles_i,
  input  logic [REP_W-1:0] repeat_i,
  input  logic             abort_i,
  output logic             wave_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o,
  output logic             done_o
);

  gen_state_e       state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] high_eff, low_eff;
  logic             dur_load, dur_dec, dur_one, dur_zero;
  logic [CNT_W-1:0] dur_val;
  logic             rep_load, rep_dec, rep_zero, rep_one;

  // Zero durations behave as one cycle.
  assign high_eff = (high_cycles_i == '0) ? CNT_W'(1) : high_cycles_i;
  assign low_eff  = (low_cycles_i == '0) ? CNT_W'(1) : low_cycles_i;

  load_down_counter #(.W(CNT_W)) u_dur_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (dur_load),
    .value_i (dur_val),
    .dec_i   (dur_dec),
    .zero_o  (dur_zero),
    .one_o   (dur_one)
  );

  // A pulse count loaded as zero never decrements, so zero marks a continuous train.
  load_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (rep_load),
    .value_i (repeat_i),
    .dec_i   (rep_dec),
    .zero_o  (rep_zero),
    .one_o   (rep_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = HIGH;
      HIGH: begin
        if (abort_i)      state_d = IDLE;
        else if (dur_one) state_d = LOW;
      end
      LOW: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (dur_one) begin
          state_d = (rep_zero || !rep_one) ? HIGH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter control, request capture and next registered outputs.
  always_comb begin
    dur_load = 1'b0;
    dur_dec  = 1'b0;
    dur_val  = high_q;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    high_d   = high_q;
    low_d    = low_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          dur_load = 1'b1;
          dur_val  = high_eff;
          rep_load = 1'b1;
          high_d   = high_eff;
          low_d    = low_eff;
        end
      end
      HIGH: begin
        if (!abort_i) begin
          if (dur_one) begin
            dur_load = 1'b1;
            dur_val  = low_q;
          end else begin
            dur_dec = 1'b1;
          end
        end
      end
      LOW: begin
        if (!abort_i) begin
          if (dur_one) begin
            rep_dec = 1'b1;
            if (state_d == HIGH) begin
              dur_load = 1'b1;
              dur_val  = high_q;
            end
          end else begin
            dur_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
    wave_d = (state_d == HIGH);
    rise_d = (state_d == HIGH) && (state_q != HIGH);
    fall_d = (state_q == HIGH) && (state_d != HIGH);
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q <= '0;
      low_q  <= '0;
      wave_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      high_q <= high_d;
      low_q  <= low_d;
      wave_q <= wave_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      done_q <= done_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wave_o      = wave_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Scoreboard bench for pulse_generator: per-cycle expected output vectors are
// queued when a request is issued and popped as the DUT advances.
module tb_pulse_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [7:0] high_cycles_i = '0;
  logic [7:0] low_cycles_i = '0;
  logic [7:0] repeat_i = '0;
  logic       abort_i = 1'b0;
  logic       wave_o, rise_o, fall_o, busy_o, done_o;

  // {ready, busy, wave, rise, fall, done}
  logic [5:0] obs;
  logic [5:0] exp_v;
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pulse_generator #(.CNT_W(8), .REP_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .high_cycles_i (high_cycles_i),
    .low_cycles_i  (low_cycles_i),
    .repeat_i      (repeat_i),
    .abort_i       (abort_i),
    .wave_o        (wave_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  assign obs = {req_ready_o, busy_o, wave_o, rise_o, fall_o, done_o};

  task automatic push_pulses(input int h, input int l, input int n);
    int heff, leff;
    heff = (h == 0) ? 1 : h;
    leff = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < heff; i++) exp_q.push_back({3'b011, (i == 0), 2'b00});
      for (int i = 0; i < leff; i++) exp_q.push_back({3'b010, 1'b0, (i == 0), 1'b0});
    end
  endtask

  task automatic push_train(input int h, input int l, input int r);
    push_pulses(h, l, r);
    exp_q.push_back(6'b100001);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs, 6'b100000);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL reset_released: got %b expected %b", obs, 6'b100000);
    end
  endtask

  task automatic test_single();
    push_train(3, 2, 1);
    exp_q.push_back(6'b100000);
    high_cycles_i = 8'd3; low_cycles_i = 8'd2; repeat_i = 8'd1;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_zero_fields();
    push_train(0, 0, 2);
    high_cycles_i = 8'd0; low_cycles_i = 8'd0; repeat_i = 8'd2;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero_fields cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_continuous_abort();
    push_pulses(2, 2, 10);
    exp_q.push_back(6'b011100);
    high_cycles_i = 8'd2; low_cycles_i = 8'd2; repeat_i = 8'd0;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL continuous cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
    // Abort in the first HIGH cycle of pulse 11.
    exp_q.push_back(6'b100011);
    exp_q.push_back(6'b100000);
    abort_i = 1'b1;
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      abort_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_high step %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    push_train(2, 1, 1);
    push_train(2, 1, 1);
    exp_q.push_back(6'b100000);
    high_cycles_i = 8'd2; low_cycles_i = 8'd1; repeat_i = 8'd1;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (exp_v[0]) begin
        dones++;
        if (dones == 2) req_valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(6'b011100);
    exp_q.push_back(6'b011000);
    exp_q.push_back(6'b010010);
    high_cycles_i = 8'd2; low_cycles_i = 8'd3; repeat_i = 8'd5;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid lead cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL reset_mid immediate: got %b expected %b", obs, 6'b100000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 6'b100000) begin
        errors++;
        $display("FAIL reset_mid after_release %0d: got %b expected %b", c, obs, 6'b100000);
      end
    end
    push_train(1, 1, 1);
    high_cycles_i = 8'd1; low_cycles_i = 8'd1; repeat_i = 8'd1;
    req_valid_i = 1'b1;
    for (int c = 1; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid new_train cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int h, l, r, rises;
    logic prev_wave;
    prev_wave = wave_o;
    for (int t = 0; t < 1000; t++) begin
      if (t == 0) begin
        h = 255; l = 255; r = 1;
      end else begin
        h = $urandom_range(0, 7);
        l = $urandom_range(0, 7);
        r = $urandom_range(1, 4);
      end
      push_train(h, l, r);
      high_cycles_i = 8'(h); low_cycles_i = 8'(l); repeat_i = 8'(r);
      req_valid_i = 1'b1;
      rises = 0;
      for (int c = 1; exp_q.size() != 0; c++) begin
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        high_cycles_i = 8'($urandom);
        low_cycles_i  = 8'($urandom);
        repeat_i      = 8'($urandom);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL random train %0d cycle %0d (H=%0d L=%0d R=%0d): got %b expected %b",
                   t, c, h, l, r, obs, exp_v);
        end
        checks++;
        if ((rise_o !== (wave_o & ~prev_wave)) || (fall_o !== (~wave_o & prev_wave))) begin
          errors++;
          $display("FAIL strobe_invariant train %0d cycle %0d: rise=%b fall=%b wave=%b prev=%b",
                   t, c, rise_o, fall_o, wave_o, prev_wave);
        end
        prev_wave = wave_o;
        if (rise_o === 1'b1) rises++;
      end
      checks++;
      if (rises != r) begin
        errors++;
        $display("FAIL rise_count train %0d: got %0d expected %0d", t, rises, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_fields();
    test_continuous_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Generates a programmable train of rectangular pulses on a single-bit line. Each request carries high time, low time and pulse count. Edge strobes are produced alongside the waveform, so downstream logic needs no separate edge detection. It sits on the transmit side of level/edge-signalled links and stimulus paths, and drives lines that edge detectors downstream consume.

## Interface
Parameters:
- CNT_W, 8, width of high/low duration fields (cycles)
- REP_W, 8, width of pulse-count field

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid_i  in  1  request present
- req_ready_o  out  1  block idle and able to accept; equals (state == IDLE)
- high_cycles_i  in  CNT_W  pulse high time; 0 treated as 1
- low_cycles_i  in  CNT_W  pulse low time; 0 treated as 1
- repeat_i  in  REP_W  pulse count; 0 = continuous until abort
- abort_i  in  1  terminate active train
- wave_o  out  1  generated waveform, registered
- rise_o  out  1  one-cycle strobe, first cycle of each high phase
- fall_o  out  1  one-cycle strobe, first cycle wave_o is low after a high phase
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle strobe, train ended (completion or abort)

## Operation
- States: IDLE, HIGH, LOW.
- IDLE:
  - Handshake req_valid_i & req_ready_o captures high, low and repeat.
  - Next state is HIGH, loaded with high count H (0→1). Sets wave_o=1 and rise_o=1.
- HIGH:
  - Holds for exactly H cycles.
  - Then goes to LOW, loaded with low count L (0→1). Sets wave_o=0 and fall_o=1.
- LOW:
  - Holds for exactly L cycles.
  - At end of LOW, the remaining-pulse counter decrements, unless repeat=0.
  - If pulses remain, or repeat=0: go to HIGH, with rise_o=1.
  - Otherwise go to IDLE with done_o=1.
- abort_i:
  - Honoured only in HIGH or LOW. Next cycle is IDLE, wave_o=0, done_o=1.
  - fall_o=1 if aborted from HIGH.
  - Ignored in IDLE. An abort_i coinciding with a handshake does not cancel the accepted request.
  - Abort on the last cycle of the final LOW gives the same result as natural completion.
- Inputs are sampled only at the handshake; changes during a train have no effect.
- Strobe consistency invariant: rise_o == wave_o & ~wave_o(prev) and fall_o == ~wave_o & wave_o(prev), every cycle.
- Counters are unsigned down-counters. No overflow is possible; max H = L = 2^CNT_W − 1.

## Timing
- Reset values: wave_o=0, rise_o=0, fall_o=0, done_o=0, busy_o=0, req_ready_o=1, state IDLE, counters 0.
- Reset mid-train forces these values immediately (asynchronous). No done_o is produced for the interrupted train.
- Latency: handshake at edge N gives wave_o=1 and rise_o=1 in cycle N+1.
- Period per pulse is H+L cycles. A train of R pulses occupies R·(H+L) cycles, followed by one IDLE cycle with done_o=1.
- done_o and req_ready_o are high in the same cycle. A request accepted then starts HIGH in the next cycle, so there is a minimum one-cycle low gap between trains.
- H=1: rise_o and fall_o land in adjacent cycles. L=1: fall_o and the next rise_o land in adjacent cycles.

## Structure
- Shared package edge_pkg:
  - typedef enum gen_state_e {IDLE, HIGH, LOW}
  - default width constants PG_CNT_W=8, PG_REP_W=8
- Sub-module load_down_counter (parameter W): load, value, decrement enable, zero/one flag.
  - One instance (W=CNT_W) for phase duration.
  - One instance (W=REP_W) for remaining pulses.
- Top module holds the FSM and the registered outputs.

## Test plan
- Single pulse, H=3 L=2 R=1, request at cycle 0:
  - wave_o high cycles 1–3, low cycles 4–5.
  - rise_o@1, fall_o@4, done_o@6, req_ready_o low cycles 1–5.
- Zero fields, H=0 L=0 R=2:
  - Behaves as H=1 L=1: wave_o = 1,0,1,0 over cycles 1–4, done_o@5.
- Continuous train, R=0 H=2 L=2:
  - 10 pulses with period 4 observed.
  - abort_i at a HIGH cycle: next cycle wave_o=0, fall_o=1, done_o=1, busy_o=0.
- Back-to-back requests:
  - req_valid_i held high; second request accepted in the done_o cycle.
  - Exactly one low gap cycle between trains.
- Reset asserted mid-LOW with R=5:
  - All outputs at reset values immediately; req_ready_o=1 and no done_o after release.
  - A new request then behaves normally.
- Random H/L/R (1000 trains):
  - Strobe invariant holds every cycle.
  - Counted rises equal R for each train.
  - Each high/low run length equals H/L.
